pipe_scroller: RTL and testbench

PIPE_SCROLLER -- requirements
Module: pipe_scroller

---
 rtl/flappy_pkg.sv | 50 +++++
 rtl/lfsr8.sv | 38 +++
 rtl/pipe_scroller.sv | 140 ++++++++++++++
 tb/tb_pipe_scroller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg -- shared constants and types for the pipe scroller.
//   Motion constants   : SPEED, PIPE_W, SPACING, WRAP
//   Gap constants      : GAP_H, GAP_MIN
//   LFSR_SEED          : non-zero power-up value of the gap LFSR
//   Reset positions    : per-pipe x0 / y1 (x1 and y0 derive from them)
//   state_t            : IDLE, RUN, DEAD
//   rst_x0 / rst_y1    : index-based lookup of the reset positions
package flappy_pkg;

   localparam logic [9:0] SPEED   = 10'd4;
   localparam logic [9:0] PIPE_W  = 10'd40;
   localparam logic [9:0] SPACING = 10'd240;
   localparam logic [9:0] WRAP    = 10'd720;
   localparam logic [8:0] GAP_H   = 9'd120;
   localparam logic [8:0] GAP_MIN = 9'd60;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Pipes start one SPACING apart so that at most one wraps per step.
   localparam logic [9:0] PIPE1_X0_RST = 10'd400;
   localparam logic [9:0] PIPE2_X0_RST = PIPE1_X0_RST + SPACING;
   localparam logic [9:0] PIPE3_X0_RST = PIPE2_X0_RST + SPACING;

   localparam logic [8:0] PIPE1_Y1_RST = 9'd180;
   localparam logic [8:0] PIPE2_Y1_RST = 9'd120;
   localparam logic [8:0] PIPE3_Y1_RST = 9'd240;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   function automatic logic [9:0] rst_x0(input int idx);
      case (idx)
         0:       rst_x0 = PIPE1_X0_RST;
         1:       rst_x0 = PIPE2_X0_RST;
         default: rst_x0 = PIPE3_X0_RST;
      endcase
   endfunction

   function automatic logic [8:0] rst_y1(input int idx);
      case (idx)
         0:       rst_y1 = PIPE1_Y1_RST;
         1:       rst_y1 = PIPE2_Y1_RST;
         default: rst_y1 = PIPE3_Y1_RST;
      endcase
   endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8 -- free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
//   clk   : system clock
//   reset : synchronous active-high, loads LFSR_SEED
//   q     : current LFSR value, never zero
module lfsr8
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] q_reg;
   logic [7:0] q_next;
   logic       feedback;

   always_comb begin
      // Taps x^8, x^6, x^5, x^4 map onto bits 7, 5, 4, 3.
      feedback = q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3];
      q_next   = {q_reg[6:0], feedback};
      // A maximal-length sequence from a non-zero seed never reaches zero;
      // this guard only recovers from a corrupted register.
      if (q_next == 8'd0) begin
         q_next = LFSR_SEED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= LFSR_SEED;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller -- game FSM plus three horizontally scrolling pipes.
//   clk, reset         : clock and synchronous active-high reset
//   start              : begin a game (IDLE) or return to IDLE (DEAD)
//   step_en            : scroll enable, pipes move only while RUN
//   game_over          : collision flag, ends the game from RUN
//   pipeN_x0 / pipeN_x1: left / right pipe edges (x1 = x0 + PIPE_W)
//   pipeN_y1 / pipeN_y0: gap top / gap bottom (y0 = y1 + GAP_H)
//   running            : 1 only while in RUN
// All outputs come straight from registers.
module pipe_scroller
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       step_en,
   input  logic       game_over,
   output logic [9:0] pipe1_x0,
   output logic [9:0] pipe1_x1,
   output logic [9:0] pipe2_x0,
   output logic [9:0] pipe2_x1,
   output logic [9:0] pipe3_x0,
   output logic [9:0] pipe3_x1,
   output logic [8:0] pipe1_y0,
   output logic [8:0] pipe1_y1,
   output logic [8:0] pipe2_y0,
   output logic [8:0] pipe2_y1,
   output logic [8:0] pipe3_y0,
   output logic [8:0] pipe3_y1,
   output logic       running
);

   state_t     state_reg;
   logic       running_reg;
   logic [7:0] lfsr_q;
   logic       advance;
   logic       reload;

   logic [9:0] x0_q [3];
   logic [9:0] x1_q [3];
   logic [8:0] y0_q [3];
   logic [8:0] y1_q [3];

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   // game_over has priority over start in RUN simply because start is
   // not looked at there; game_over is ignored outside RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         running_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= RUN;
                  running_reg <= 1'b1;
               end
            end
            RUN: begin
               if (game_over) begin
                  state_reg   <= DEAD;
                  running_reg <= 1'b0;
               end
            end
            DEAD: begin
               if (start) begin
                  state_reg   <= IDLE;
                  running_reg <= 1'b0;
               end
            end
            default: begin
               state_reg   <= IDLE;
               running_reg <= 1'b0;
            end
         endcase
      end
   end

   assign advance = (state_reg == RUN) && step_en;
   assign reload  = (state_reg == DEAD) && start;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pipe
         logic [9:0] x0_reg;
         logic [9:0] x1_reg;
         logic [8:0] y0_reg;
         logic [8:0] y1_reg;
         logic [9:0] x0_next;
         logic [8:0] y1_next;
         logic       wrap;

         always_comb begin
            wrap    = (x0_reg < SPEED);
            // A wrapping pipe re-enters on the right with a fresh gap taken
            // from the LFSR value held before this edge.
            x0_next = wrap ? (x0_reg + (WRAP - SPEED)) : (x0_reg - SPEED);
            y1_next = wrap ? (GAP_MIN + {1'b0, lfsr_q}) : y1_reg;
         end

         always_ff @(posedge clk) begin
            if (reset || reload) begin
               x0_reg <= rst_x0(gi);
               x1_reg <= rst_x0(gi) + PIPE_W;
               y1_reg <= rst_y1(gi);
               y0_reg <= rst_y1(gi) + GAP_H;
            end else if (advance) begin
               x0_reg <= x0_next;
               x1_reg <= x0_next + PIPE_W;
               y1_reg <= y1_next;
               y0_reg <= y1_next + GAP_H;
            end
         end

         assign x0_q[gi] = x0_reg;
         assign x1_q[gi] = x1_reg;
         assign y0_q[gi] = y0_reg;
         assign y1_q[gi] = y1_reg;
      end
   endgenerate

   assign pipe1_x0 = x0_q[0];
   assign pipe1_x1 = x1_q[0];
   assign pipe1_y0 = y0_q[0];
   assign pipe1_y1 = y1_q[0];
   assign pipe2_x0 = x0_q[1];
   assign pipe2_x1 = x1_q[1];
   assign pipe2_y0 = y0_q[1];
   assign pipe2_y1 = y1_q[1];
   assign pipe3_x0 = x0_q[2];
   assign pipe3_x1 = x1_q[2];
   assign pipe3_y0 = y0_q[2];
   assign pipe3_y1 = y1_q[2];
   assign running  = running_reg;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller -- self-checking bench for pipe_scroller.
// A behavioural game model tracks expected positions every cycle; a table
// of directed vectors, hand sequences and a random phase drive the DUT.
module tb_pipe_scroller;

   logic       clk;
   logic       reset;
   logic       start;
   logic       step_en;
   logic       game_over;
   logic [9:0] pipe1_x0, pipe1_x1, pipe2_x0, pipe2_x1, pipe3_x0, pipe3_x1;
   logic [8:0] pipe1_y0, pipe1_y1, pipe2_y0, pipe2_y1, pipe3_y0, pipe3_y1;
   logic       running;

   int errors = 0;
   int checks = 0;
   bit armed  = 0;

   // Behavioural model: 0=idle, 1=run, 2=dead
   int       m_state;
   int       m_x0 [3];
   int       m_y1 [3];
   bit [7:0] m_lfsr;

   pipe_scroller dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .step_en   (step_en),
      .game_over (game_over),
      .pipe1_x0  (pipe1_x0),
      .pipe1_x1  (pipe1_x1),
      .pipe2_x0  (pipe2_x0),
      .pipe2_x1  (pipe2_x1),
      .pipe3_x0  (pipe3_x0),
      .pipe3_x1  (pipe3_x1),
      .pipe1_y0  (pipe1_y0),
      .pipe1_y1  (pipe1_y1),
      .pipe2_y0  (pipe2_y0),
      .pipe2_y1  (pipe2_y1),
      .pipe3_y0  (pipe3_y0),
      .pipe3_y1  (pipe3_y1),
      .running   (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset_pipes();
      m_x0[0] = 400; m_x0[1] = 640; m_x0[2] = 880;
      m_y1[0] = 180; m_y1[1] = 120; m_y1[2] = 240;
   endtask

   // Model of one clock edge using the inputs sampled at that edge.
   task automatic model_edge(input bit r, input bit s, input bit st, input bit go);
      bit [7:0] nxt;
      nxt = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (r) begin
         m_state = 0;
         model_reset_pipes();
         m_lfsr = 8'hA5;
      end else begin
         if (m_state == 0) begin
            if (s) m_state = 1;
         end else if (m_state == 1) begin
            if (st) begin
               for (int p = 0; p < 3; p++) begin
                  if (m_x0[p] >= 4) m_x0[p] = m_x0[p] - 4;
                  else begin
                     m_x0[p] = m_x0[p] + 720 - 4;
                     m_y1[p] = 60 + int'(m_lfsr);
                  end
               end
            end
            if (go) m_state = 2;
         end else begin
            if (s) begin
               m_state = 0;
               model_reset_pipes();
            end
         end
         m_lfsr = nxt;
      end
   endtask

   task automatic compare_model();
      check("p1_x0", pipe1_x0, m_x0[0]);
      check("p1_x1", pipe1_x1, m_x0[0] + 40);
      check("p1_y1", pipe1_y1, m_y1[0]);
      check("p1_y0", pipe1_y0, m_y1[0] + 120);
      check("p2_x0", pipe2_x0, m_x0[1]);
      check("p2_x1", pipe2_x1, m_x0[1] + 40);
      check("p2_y1", pipe2_y1, m_y1[1]);
      check("p2_y0", pipe2_y0, m_y1[1] + 120);
      check("p3_x0", pipe3_x0, m_x0[2]);
      check("p3_x1", pipe3_x1, m_x0[2] + 40);
      check("p3_y1", pipe3_y1, m_y1[2]);
      check("p3_y0", pipe3_y0, m_y1[2] + 120);
      check("running", running, (m_state == 1) ? 1 : 0);
   endtask

   // Apply one cycle of inputs, advance the model, compare after the edge.
   task automatic cyc(input bit r, input bit s, input bit st, input bit go);
      reset = r; start = s; step_en = st; game_over = go;
      @(posedge clk);
      model_edge(r, s, st, go);
      #1;
      armed = 1;
      compare_model();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_p1x0"}, pipe1_x0, 400);
      check({tag, "_p1x1"}, pipe1_x1, 440);
      check({tag, "_p1y1"}, pipe1_y1, 180);
      check({tag, "_p1y0"}, pipe1_y0, 300);
      check({tag, "_p2x0"}, pipe2_x0, 640);
      check({tag, "_p2x1"}, pipe2_x1, 680);
      check({tag, "_p2y1"}, pipe2_y1, 120);
      check({tag, "_p2y0"}, pipe2_y0, 240);
      check({tag, "_p3x0"}, pipe3_x0, 880);
      check({tag, "_p3x1"}, pipe3_x1, 920);
      check({tag, "_p3y1"}, pipe3_y1, 240);
      check({tag, "_p3y0"}, pipe3_y0, 360);
      check({tag, "_run"},  running, 0);
   endtask

   // Continuous invariants on every cycle once reset has been applied.
   always @(negedge clk) begin
      if (armed) begin
         check("inv_w1", pipe1_x1 - pipe1_x0, 40);
         check("inv_w2", pipe2_x1 - pipe2_x0, 40);
         check("inv_w3", pipe3_x1 - pipe3_x0, 40);
         check("inv_g1", pipe1_y0 - pipe1_y1, 120);
         check("inv_g2", pipe2_y0 - pipe2_y1, 120);
         check("inv_g3", pipe3_y0 - pipe3_y1, 120);
         check("inv_ylim", (pipe1_y0 < 480 && pipe2_y0 < 480 && pipe3_y0 < 480) ? 1 : 0, 1);
         check("inv_lfsr_nz", (dut.u_lfsr.q != 8'd0) ? 1 : 0, 1);
      end
   end

   typedef struct {
      bit r;
      bit s;
      bit st;
      bit go;
      int exp_run;
      int exp_p1x0;
      int exp_p2x0;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int prev_lfsr;
      reset = 1; start = 0; step_en = 0; game_over = 0;
      m_lfsr = 8'hA5;
      m_state = 0;
      model_reset_pipes();

      // Directed table: r, start, step, game_over, running, p1_x0, p2_x0
      vecs[0]  = '{1, 0, 0, 0, 0, 400, 640};
      vecs[1]  = '{0, 1, 1, 0, 1, 400, 640};  // idle->run, no move yet
      vecs[2]  = '{0, 0, 1, 0, 1, 396, 636};
      vecs[3]  = '{0, 0, 0, 0, 1, 396, 636};
      vecs[4]  = '{0, 1, 1, 0, 1, 392, 632};  // start ignored in run
      vecs[5]  = '{0, 0, 0, 1, 0, 392, 632};  // game over
      vecs[6]  = '{0, 0, 1, 0, 0, 392, 632};  // frozen in dead
      vecs[7]  = '{0, 1, 0, 0, 0, 400, 640};  // dead->idle reload
      vecs[8]  = '{0, 0, 1, 0, 0, 400, 640};  // idle holds
      vecs[9]  = '{0, 0, 0, 1, 0, 400, 640};  // game_over ignored in idle
      vecs[10] = '{0, 1, 0, 0, 1, 400, 640};
      vecs[11] = '{0, 0, 1, 0, 1, 396, 636};
      vecs[12] = '{1, 1, 1, 1, 0, 400, 640};  // reset wins over all

      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].go);
         check($sformatf("vec%0d_run", i), running, vecs[i].exp_run);
         check($sformatf("vec%0d_p1x0", i), pipe1_x0, vecs[i].exp_p1x0);
         check($sformatf("vec%0d_p2x0", i), pipe2_x0, vecs[i].exp_p2x0);
         $display("vec %0d: r=%0d s=%0d st=%0d go=%0d -> run=%0d p1x0=%0d p2x0=%0d",
                  i, vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].go, running, pipe1_x0, pipe2_x0);
      end

      // Idle after reset with step_en high for 10 cycles
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
      check_reset_values("idle10");
      $display("seq idle10: p1x0=%0d running=%0d", pipe1_x0, running);

      // Start then one step
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      check("s1_run", running, 1);
      check("s1_p1x0", pipe1_x0, 396);
      check("s1_p1x1", pipe1_x1, 436);
      check("s1_p2x0", pipe2_x0, 636);
      check("s1_p3x0", pipe3_x0, 876);
      check("s1_p1y1", pipe1_y1, 180);
      check("s1_p3y0", pipe3_y0, 360);
      $display("seq step1: p1x0=%0d p2x0=%0d p3x0=%0d", pipe1_x0, pipe2_x0, pipe3_x0);

      // 100 steps from start, then a wrap of pipe1
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0);
      check("w_p1x0_zero", pipe1_x0, 0);
      prev_lfsr = int'(m_lfsr);
      cyc(0, 0, 1, 0);
      check("w_p1x0", pipe1_x0, 716);
      check("w_p1x1", pipe1_x1, 756);
      check("w_p1y1", pipe1_y1, 60 + prev_lfsr);
      check("w_p1y0", pipe1_y0, 180 + prev_lfsr);
      check("w_p2x0", pipe2_x0, 236);
      check("w_p3x0", pipe3_x0, 476);
      $display("seq wrap: p1x0=%0d p1y1=%0d lfsr_prev=%0d", pipe1_x0, pipe1_y1, prev_lfsr);

      // Toggled steps, then game over and freeze, then start back to idle
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("tog_p1x0", pipe1_x0, 708);
      cyc(0, 0, 0, 1);
      check("go_run", running, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
      check("frz_p1x0", pipe1_x0, 708);
      check("frz_p2x0", pipe2_x0, 228);
      cyc(0, 1, 0, 0);
      check_reset_values("restart");
      cyc(0, 0, 1, 0);
      check("idle_hold_p1x0", pipe1_x0, 400);
      $display("seq dead/restart: p1x0=%0d running=%0d", pipe1_x0, running);

      // game_over and start together in RUN -> DEAD
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 1);
      check("both_run", running, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
      check("both_frz", pipe1_x0, 396);
      cyc(0, 1, 0, 0);   // from DEAD this returns to IDLE with reload
      check("both_dead_run", running, 0);
      check("both_dead_p1x0", pipe1_x0, 400);
      $display("seq go+start: running=%0d p1x0=%0d", running, pipe1_x0);

      // Reset mid-run
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0);
      check("mid_p1x0", pipe1_x0, 200);
      cyc(1, 0, 1, 0);
      check_reset_values("midrst");
      check("midrst_lfsr", dut.u_lfsr.q, 8'hA5);
      $display("seq midreset: p1x0=%0d lfsr=%0h", pipe1_x0, dut.u_lfsr.q);

      // Randomized play against the model
      for (int i = 0; i < 3000; i++) begin
         bit r, s, st, go;
         r  = ($urandom_range(0, 399) == 0);
         s  = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 3) != 0);
         go = ($urandom_range(0, 59) == 0);
         cyc(r, s, st, go);
         if (i % 500 == 0)
            $display("rand %0d: r=%0d s=%0d st=%0d go=%0d p1x0=%0d run=%0d",
                     i, r, s, st, go, pipe1_x0, running);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
